// File: rtl/csm_pipe_mult_n.sv
// csm_pipe_mult_n
//   Pipelined carry-save array multiplier for signed or unsigned operands.
//   The mode is chosen per operation. Signed products use Baugh-Wooley
//   correction, so a single unsigned-style array serves both modes.
//
//   Pipeline: input register -> STAGES carry-save stages -> carry-propagate
//   register. Each carry-save stage folds ROWS_PER_STAGE partial-product
//   rows into the running sum/carry pair. Latency is L = STAGES + 2 enabled
//   cycles, and throughput is one operation per enabled cycle.
//
//   Handshake: in_valid qualifies a/b/sgn on an edge with en=1. There is no
//   backpressure. en=0 freezes every register, including y and out_valid.
//   out_valid qualifies y. y keeps the last valid product until a newer
//   valid result overwrites it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; it has priority over en
//   en         pipeline advance enable
//   in_valid   operand qualifier
//   a, b       multiplicand / multiplier, WIDTH bits
//   sgn        1 = two's-complement signed, 0 = unsigned
//   y          product, 2*WIDTH bits
//   out_valid  result qualifier
module csm_pipe_mult_n #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic [2*WIDTH-1:0]   y,
    output logic                 out_valid
);
    localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_W = ONE_W << (WIDTH - 1);
    localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};
    // Baugh-Wooley constant: ones at bit WIDTH and bit 2*WIDTH-1.
    localparam logic [PW-1:0]    BW_CONST = (ONE_P << WIDTH) | (ONE_P << (PW - 1));

    // Index 0 is the input register. Index k+1 is the output of carry-save
    // stage k. Operands are needed only up to the last stage's input.
    logic [WIDTH-1:0] r_a     [0:STAGES-1];
    logic [WIDTH-1:0] r_b     [0:STAGES-1];
    logic             r_sgn   [0:STAGES-1];
    logic [PW-1:0]    r_sum   [0:STAGES];
    logic [PW-1:0]    r_carry [0:STAGES];
    logic             r_vld   [0:STAGES];
    logic [PW-1:0]    r_y;
    logic             r_out_valid;

    logic [PW-1:0]    w_sum_nxt   [0:STAGES-1];
    logic [PW-1:0]    w_carry_nxt [0:STAGES-1];

    // This function builds one partial-product row, already shifted into
    // place. In signed mode, the cross terms that involve exactly one operand
    // MSB are inverted: bit WIDTH-1 of rows 0..WIDTH-2, and bits
    // 0..WIDTH-2 of the last row.
    function automatic logic [PW-1:0] row_pp(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic             fs,
        input int               row
    );
        logic             b_bit;
        logic [WIDTH-1:0] bits;
        logic [WIDTH-1:0] inv;
        b_bit = |(fb & (ONE_W << row));
        bits  = fa & {WIDTH{b_bit}};
        inv   = '0;
        if (fs) begin
            inv = (row == WIDTH - 1) ? ~MSB_W : MSB_W;
        end
        return {{WIDTH{1'b0}}, bits ^ inv} << row;
    endfunction

    // This block holds the carry-save stages as 3:2 compressor rows. No carry
    // is propagated here. Carries overflowing bit 2*WIDTH-1 are dropped,
    // because the result is defined modulo 2^(2*WIDTH).
    always_comb begin
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] pp;
        logic [PW-1:0] s_n;
        s   = '0;
        c   = '0;
        pp  = '0;
        s_n = '0;
        for (int k = 0; k < STAGES; k++) begin
            s = r_sum[k];
            c = r_carry[k];
            for (int r = 0; r < ROWS_PER_STAGE; r++) begin
                if (k * ROWS_PER_STAGE + r < WIDTH) begin
                    pp  = row_pp(r_a[k], r_b[k], r_sgn[k], k * ROWS_PER_STAGE + r);
                    s_n = s ^ c ^ pp;
                    c   = ((s & c) | (s & pp) | (c & pp)) << 1;
                    s   = s_n;
                end
            end
            w_sum_nxt[k]   = s;
            w_carry_nxt[k] = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sgn[k] <= 1'b0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                r_sum[k]   <= '0;
                r_carry[k] <= '0;
                r_vld[k]   <= 1'b0;
            end
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_a[0]     <= a;
            r_b[0]     <= b;
            r_sgn[0]   <= sgn;
            r_vld[0]   <= in_valid;
            // The correction constant seeds the sum vector, so every
            // carry-save stage sees only partial-product rows.
            r_sum[0]   <= sgn ? BW_CONST : '0;
            r_carry[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_sgn[k] <= r_sgn[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k+1]   <= w_sum_nxt[k];
                r_carry[k+1] <= w_carry_nxt[k];
                r_vld[k+1]   <= r_vld[k];
            end
            if (r_vld[STAGES]) begin
                r_y <= r_sum[STAGES] + r_carry[STAGES];
            end
            r_out_valid <= r_vld[STAGES];
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_csm_pipe_mult_n.sv
// tb_csm_pipe_mult_n
//   Bench for csm_pipe_mult_n with three instances:
//     u_w8  : WIDTH=8,  ROWS_PER_STAGE=2
//     u_w4  : WIDTH=4,  ROWS_PER_STAGE=1
//     u_w16 : WIDTH=16, ROWS_PER_STAGE=4
//   All three share clk, rst and en. Each instance has a valid-bit delay
//   line of depth L and an expected-product queue. The product comes from
//   plain integer multiplication, or from a table constant for the
//   directed vectors.
`timescale 1ns/1ps
module tb_csm_pipe_mult_n;
    localparam int L = 6;

    typedef struct packed {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] e;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        iv0, s0, ov0;
    logic [7:0]  a0, b0;
    logic [15:0] y0;
    logic        iv1, s1, ov1;
    logic [3:0]  a1, b1;
    logic [7:0]  y1;
    logic        iv2, s2, ov2;
    logic [15:0] a2, b2;
    logic [31:0] y2;

    csm_pipe_mult_n #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv0), .a(a0), .b(b0),
        .sgn(s0), .y(y0), .out_valid(ov0)
    );
    csm_pipe_mult_n #(.WIDTH(4), .ROWS_PER_STAGE(1)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv1), .a(a1), .b(b1),
        .sgn(s1), .y(y1), .out_valid(ov1)
    );
    csm_pipe_mult_n #(.WIDTH(16), .ROWS_PER_STAGE(4)) u_w16 (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv2), .a(a2), .b(b2),
        .sgn(s2), .y(y2), .out_valid(ov2)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [L-1:0] vl0 = '0, vl1 = '0, vl2 = '0;
    logic        eov0 = 1'b0, eov1 = 1'b0, eov2 = 1'b0;
    logic [15:0] ey0 = '0;
    logic [7:0]  ey1 = '0;
    logic [31:0] ey2 = '0;
    logic [15:0] pend0 = '0;

    // Reference product: operands are interpreted as w-bit values, signed
    // or unsigned. The result is reduced modulo 2^(2w).
    function automatic logic [31:0] ref_prod(input int w, input logic [15:0] x,
                                             input logic [15:0] z, input logic s);
        longint xv, zv, p;
        xv = longint'(x);
        zv = longint'(z);
        if (s) begin
            if (xv >= (64'sd1 <<< (w - 1))) xv = xv - (64'sd1 <<< w);
            if (zv >= (64'sd1 <<< (w - 1))) zv = zv - (64'sd1 <<< w);
        end
        p = xv * zv;
        return 32'(p & ((64'sd1 <<< (2 * w)) - 64'sd1));
    endfunction

    function automatic logic [15:0] rand_op(input int w);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 16'(32'd1 << (w - 1));
            1:       return mask;
            2:       return 16'd0;
            default: return 16'($urandom) & mask;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_underflow(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got out_valid with empty expected queue at %0t", nm, $time);
    endtask

    // The model advances on the same edge as the DUT. It sees the inputs
    // that were applied for that edge.
    task automatic model_edge();
        if (rst) begin
            vl0 = '0; vl1 = '0; vl2 = '0;
            eov0 = 1'b0; eov1 = 1'b0; eov2 = 1'b0;
            ey0 = '0; ey1 = '0; ey2 = '0;
            exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        end else if (en) begin
            if (iv0) exp_q0.push_back(pend0);
            if (iv1) exp_q1.push_back(8'(ref_prod(4, {12'd0, a1}, {12'd0, b1}, s1)));
            if (iv2) exp_q2.push_back(ref_prod(16, a2, b2, s2));
            vl0 = {vl0[L-2:0], iv0};
            vl1 = {vl1[L-2:0], iv1};
            vl2 = {vl2[L-2:0], iv2};
            eov0 = vl0[L-1];
            eov1 = vl1[L-1];
            eov2 = vl2[L-1];
            if (eov0) begin
                if (exp_q0.size() == 0) sb_underflow("w8 scoreboard");
                else ey0 = exp_q0.pop_front();
            end
            if (eov1) begin
                if (exp_q1.size() == 0) sb_underflow("w4 scoreboard");
                else ey1 = exp_q1.pop_front();
            end
            if (eov2) begin
                if (exp_q2.size() == 0) sb_underflow("w16 scoreboard");
                else ey2 = exp_q2.pop_front();
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("w8 out_valid",  32'(ov0), 32'(eov0));
        check("w8 y",          32'(y0),  32'(ey0));
        check("w4 out_valid",  32'(ov1), 32'(eov1));
        check("w4 y",          32'(y1),  32'(ey1));
        check("w16 out_valid", 32'(ov2), 32'(eov2));
        check("w16 y",         y2,       ey2);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic v, input logic s, input logic [7:0] x,
                          input logic [7:0] z, input logic [15:0] e);
        iv0 = v; s0 = s; a0 = x; b0 = z; pend0 = e;
    endtask

    task automatic idle_all();
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); s0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); s1 = 1'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom); s2 = 1'($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        tbl[14];
        int          n_en;
        int          stall;
        int          pulses;
        logic        seen;
        logic [15:0] x, z;
        logic        sv;

        tbl[0]  = '{1'b1, 8'h04, 8'hFE, 16'hFFF8};  //  4 * -2
        tbl[1]  = '{1'b1, 8'hF8, 8'h07, 16'hFFC8};  // -8 *  7
        tbl[2]  = '{1'b1, 8'h05, 8'hFC, 16'hFFEC};  //  5 * -4
        tbl[3]  = '{1'b1, 8'h07, 8'h07, 16'h0031};  //  7 *  7
        tbl[4]  = '{1'b1, 8'h80, 8'h80, 16'h4000};  // -128 * -128
        tbl[5]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};  // -128 * 127
        tbl[6]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};  // 255 * 255
        tbl[7]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};  // 0 * 255
        tbl[8]  = '{1'b1, 8'hFF, 8'h02, 16'hFFFE};  // -1 * 2
        tbl[9]  = '{1'b0, 8'hFF, 8'h02, 16'h01FE};  // 255 * 2
        tbl[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};  // 128 * 128
        tbl[11] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};  // 127 * 127
        tbl[12] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};  // -1 * -1
        tbl[13] = '{1'b0, 8'h0F, 8'h10, 16'h00F0};  // 15 * 16

        // Reset with valid operands present: they must be dropped.
        rst = 1'b1; en = 1'b1;
        idle_all();
        drive0(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000);
        iv1 = 1'b1; iv2 = 1'b1;
        cycle();
        en = 1'b0;
        cycle();
        rst = 1'b0; en = 1'b1;
        idle_all();
        for (int i = 0; i < L + 2; i++) cycle();

        // Directed table: back-to-back issue, mixed modes.
        for (int i = 0; i < 14; i++) begin
            drive0(1'b1, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].e);
            cycle();
        end
        idle_all();
        for (int i = 0; i < L + 2; i++) cycle();

        // Stall mid-flight: 3 * -2 must appear after exactly L enabled edges.
        drive0(1'b1, 1'b1, 8'h03, 8'hFE, 16'hFFFA);
        cycle();
        n_en = 1;
        idle_all();
        stall = 5;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (n_en == 3 && stall > 0) begin
                en = 1'b0;
                stall--;
                drive0(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 16'hDEAD);
            end else begin
                en = 1'b1;
                iv0 = 1'b0;
            end
            cycle();
            if (en) n_en++;
            if (ov0) seen = 1'b1;
        end
        en = 1'b1;
        check("stall latency", 32'(n_en), 32'(L));
        check("stall y", 32'(y0), 32'h0000FFFA);
        idle_all();
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-flight: two issued operations plus one presented with rst.
        drive0(1'b1, 1'b1, 8'h09, 8'hF7, 16'hFFAF);
        cycle();
        drive0(1'b1, 1'b0, 8'h10, 8'h10, 16'h0100);
        cycle();
        rst = 1'b1;
        drive0(1'b1, 1'b1, 8'h7F, 8'h80, 16'hC080);
        cycle();
        check("reset y clear", 32'(y0), 32'd0);
        check("reset out_valid clear", 32'(ov0), 32'd0);
        rst = 1'b0;
        idle_all();
        pulses = 0;
        for (int i = 0; i < L + 4; i++) begin
            cycle();
            if (ov0) pulses++;
        end
        check("reset flushed pulses", 32'(pulses), 32'd0);

        // Randomised phase on all three widths.
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 7) != 0);
            x = rand_op(8); z = rand_op(8); sv = 1'($urandom);
            drive0($urandom_range(0, 4) != 0, sv, x[7:0], z[7:0],
                   16'(ref_prod(8, x, z, sv)));
            iv1 = ($urandom_range(0, 4) != 0);
            s1  = 1'($urandom);
            a1  = 4'(rand_op(4));
            b1  = 4'(rand_op(4));
            iv2 = ($urandom_range(0, 4) != 0);
            s2  = 1'($urandom);
            a2  = rand_op(16);
            b2  = rand_op(16);
            cycle();
        end
        rst = 1'b0; en = 1'b1;
        idle_all();
        for (int i = 0; i < L + 2; i++) cycle();
        check("w8 queue drained",  32'(exp_q0.size()), 32'd0);
        check("w4 queue drained",  32'(exp_q1.size()), 32'd0);
        check("w16 queue drained", 32'(exp_q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
